console_writer: RTL
===================

Name: console_writer

Overview:
- Host-side writer for the HDMI text console's character and attribute RAM.
- Accepts one byte per handshake with an attribute; printable bytes go to RAM at the cursor.
- Control bytes move the cursor or clear the screen.
- Scrolls by advancing RAM_ROW_OFFSET after blanking the incoming row, so the display pipeline scrolls without moving RAM contents.
- Sits in the CLOCK_CORE domain between the XLR8 register interface and the write port of the dual-port character/attribute RAM.

Parameters:
- COLS, 80, visible columns (1..128).
- ROWS, 30, visible rows (1..63).
- FILL_CHAR, 8'h20, character written by clears, scrolls and backspace.

Ports:
- CLOCK_CORE  input  1  core clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- CHAR_VALID  input  1  host byte valid.
- CHAR_READY  output  1  writer can accept a byte.
- CHAR_DATA  input  8  character code or control byte.
- CHAR_ATTR  input  8  attribute for this byte; also the fill attribute for clears it triggers.
- RAM_WR_ADDRESS  output  13  {physical_row[5:0], col[6:0]}.
- RAM_CHAR_WDATA  output  8  character write data.
- RAM_ATTR_WDATA  output  8  attribute write data.
- RAM_CHAR_WE  output  1  character RAM write enable.
- RAM_ATTR_WE  output  1  attribute RAM write enable; always equal to RAM_CHAR_WE.
- RAM_ROW_OFFSET  output  8  row offset to the display; range 0..63, bits [7:6] always 0.
- CURSOR_COL  output  7  logical cursor column.
- CURSOR_ROW  output  6  logical cursor row (0..ROWS-1).
- BUSY  output  1  equals !CHAR_READY.

Behaviour:
- Reset values:
  - state IDLE; CHAR_READY=1.
  - All RAM_* outputs 0; RAM_ROW_OFFSET=0; cursor (0,0).
  - RAM contents are not cleared.
  - Reset asserted mid-operation aborts immediately; partial clears are left as they are.
- Physical row = (logical_row + RAM_ROW_OFFSET) mod 64, computed in 6 bits.
- Handshake:
  - Accept occurs when CHAR_VALID & CHAR_READY; data and attribute are captured on that edge.
  - CHAR_READY=1 only in IDLE and deasserts the cycle after an accept.
  - VALID may be held; no byte is lost or duplicated.
- States: IDLE, PUT, CLEAR_ROW, CLEAR_ALL.
- IDLE, on accept, decode the captured byte:
  - 0x0D (CR): col=0; stays IDLE; READY returns the following cycle.
  - 0x0A (LF): performs a newline (see below).
  - 0x08 (BS):
    - col>0: col--, then PUT writes FILL_CHAR at the new position.
    - col==0: no-op, no write, no move to the previous row.
  - 0x0C (FF): enter CLEAR_ALL.
  - Any other byte: PUT.
- PUT (one cycle):
  - WE=1, address = cursor position, data = captured byte and attribute.
  - Write strobe is exactly one cycle after the accept cycle.
  - After a printable write: col++; if col was COLS-1, col=0 and newline.
- Newline:
  - If row<ROWS-1: row++, back to IDLE.
  - Else enter CLEAR_ROW.
- CLEAR_ROW:
  - Target physical row = (ROWS + RAM_ROW_OFFSET) mod 64.
  - Writes FILL_CHAR and the captured attribute at cols 0..COLS-1, one per cycle (COLS cycles).
  - Cycle after the last write: RAM_ROW_OFFSET = (offset+1) mod 64; row stays ROWS-1; col=0; IDLE.
  - Offset never changes while a write to the incoming row is pending.
- CLEAR_ALL:
  - Writes fill to every physical row 0..63 × cols 0..COLS-1, row-major, 64*COLS cycles.
  - Then offset=0, cursor (0,0), IDLE.
- Columns COLS..127 are never written.
- WE is never asserted outside PUT, CLEAR_ROW and CLEAR_ALL.

Test Plan:
- Reset, then send 'A' (0x41) with attribute 0x1F at (0,0): accept at cycle N; cycle N+1 has WE=1, addr=0x0000, char 0x41, attr 0x1F; CURSOR_COL=1; READY high at N+2.
- 80 bytes 0x30 from (0,0): last write addr=0x004F; cursor ends (1,0); no CLEAR_ROW entered.
- Cursor at row 29, offset 63, send LF with attribute 0x07:
  - 80 writes to physical row 29 (addr 0x0E80..0x0ECF), data 0x20/0x07.
  - RAM_ROW_OFFSET then 0; READY low for exactly 81 cycles after the accept.
- FF: 5120 WE pulses covering all rows, cols 0..79.
  - Address 0x0050 never written.
  - Offset and cursor end at 0; a VALID held throughout is accepted only after completion.
- BS at col 0: no write, cursor unchanged. BS at col 5: write 0x20 at col 4; CURSOR_COL=4.
- RESET asserted on cycle 100 of a CLEAR_ALL: next cycle WE=0, READY=1, offset 0, cursor (0,0).

Source files
------------

// File: rtl/console_writer.sv
// Host-side writer for the text console character/attribute RAM: places bytes at the
// cursor, handles CR/LF/BS/FF, and scrolls by blanking the incoming row then bumping the row offset.
module console_writer #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic        CLOCK_CORE,
  input  logic        RESET,
  input  logic        CHAR_VALID,
  output logic        CHAR_READY,
  input  logic [7:0]  CHAR_DATA,
  input  logic [7:0]  CHAR_ATTR,
  output logic [12:0] RAM_WR_ADDRESS,
  output logic [7:0]  RAM_CHAR_WDATA,
  output logic [7:0]  RAM_ATTR_WDATA,
  output logic        RAM_CHAR_WE,
  output logic        RAM_ATTR_WE,
  output logic [7:0]  RAM_ROW_OFFSET,
  output logic [6:0]  CURSOR_COL,
  output logic [5:0]  CURSOR_ROW,
  output logic        BUSY
);

  localparam logic [6:0] LP_LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] LP_LAST_ROW = 6'(ROWS - 1);
  localparam logic [5:0] LP_ROWS     = 6'(ROWS);

  typedef enum logic [1:0] {ST_IDLE, ST_PUT, ST_CLEAR_ROW, ST_CLEAR_ALL} state_t;

  state_t     r_state, w_state;
  logic       r_acc, w_acc;
  logic       r_bs, w_bs;
  logic       r_clr_done, w_clr_done;
  logic [7:0] r_data, w_data;
  logic [7:0] r_attr, w_attr;
  logic [6:0] r_col, w_col;
  logic [5:0] r_row, w_row;
  logic [5:0] r_offset, w_offset;
  logic [6:0] r_clr_col, w_clr_col;
  logic [5:0] r_clr_row, w_clr_row;

  logic        w_accept;
  logic [5:0]  w_phys_row;
  logic [5:0]  w_scroll_row;
  logic        w_we;
  logic [12:0] w_addr;
  logic [7:0]  w_cdata;
  logic [7:0]  w_adata;

  // r_acc holds READY low for the cycle after any accept, including those that stay in IDLE
  assign CHAR_READY     = (r_state == ST_IDLE) && !r_acc;
  assign BUSY           = !CHAR_READY;
  assign w_accept       = CHAR_VALID && CHAR_READY;
  assign w_phys_row     = r_row + r_offset;
  assign w_scroll_row   = LP_ROWS + r_offset;
  assign RAM_WR_ADDRESS = w_addr;
  assign RAM_CHAR_WDATA = w_cdata;
  assign RAM_ATTR_WDATA = w_adata;
  assign RAM_CHAR_WE    = w_we;
  assign RAM_ATTR_WE    = w_we;
  assign RAM_ROW_OFFSET = {2'b00, r_offset};
  assign CURSOR_COL     = r_col;
  assign CURSOR_ROW     = r_row;

  always_comb begin
    w_state    = r_state;
    w_acc      = w_accept;
    w_bs       = r_bs;
    w_clr_done = r_clr_done;
    w_data     = r_data;
    w_attr     = r_attr;
    w_col      = r_col;
    w_row      = r_row;
    w_offset   = r_offset;
    w_clr_col  = r_clr_col;
    w_clr_row  = r_clr_row;
    w_we       = 1'b0;
    w_addr     = 13'd0;
    w_cdata    = 8'd0;
    w_adata    = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_data = CHAR_DATA;
          w_attr = CHAR_ATTR;
          w_bs   = 1'b0;
          case (CHAR_DATA)
            8'h0D: w_col = 7'd0;
            8'h0A: begin
              if (r_row < LP_LAST_ROW) begin
                w_row = r_row + 6'd1;
              end else begin
                w_state    = ST_CLEAR_ROW;
                w_clr_col  = 7'd0;
                w_clr_done = 1'b0;
              end
            end
            8'h08: begin
              if (r_col != 7'd0) begin
                w_col   = r_col - 7'd1;
                w_data  = FILL_CHAR;
                w_bs    = 1'b1;
                w_state = ST_PUT;
              end else begin
                w_col = r_col;
              end
            end
            8'h0C: begin
              w_state   = ST_CLEAR_ALL;
              w_clr_col = 7'd0;
              w_clr_row = 6'd0;
            end
            default: w_state = ST_PUT;
          endcase
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_PUT: begin
        w_we    = 1'b1;
        w_addr  = {w_phys_row, r_col};
        w_cdata = r_data;
        w_adata = r_attr;
        w_state = ST_IDLE;
        // backspace already moved the cursor before the write
        if (r_bs) begin
          w_col = r_col;
        end else if (r_col == LP_LAST_COL) begin
          w_col = 7'd0;
          if (r_row < LP_LAST_ROW) begin
            w_row = r_row + 6'd1;
          end else begin
            w_state    = ST_CLEAR_ROW;
            w_clr_col  = 7'd0;
            w_clr_done = 1'b0;
          end
        end else begin
          w_col = r_col + 7'd1;
        end
      end
      ST_CLEAR_ROW: begin
        if (!r_clr_done) begin
          w_we    = 1'b1;
          w_addr  = {w_scroll_row, r_clr_col};
          w_cdata = FILL_CHAR;
          w_adata = r_attr;
          if (r_clr_col == LP_LAST_COL) begin
            w_clr_done = 1'b1;
          end else begin
            w_clr_col = r_clr_col + 7'd1;
          end
        end else begin
          // the incoming row is fully blanked, so it is now safe to expose it
          w_offset = r_offset + 6'd1;
          w_col    = 7'd0;
          w_state  = ST_IDLE;
        end
      end
      ST_CLEAR_ALL: begin
        w_we    = 1'b1;
        w_addr  = {r_clr_row, r_clr_col};
        w_cdata = FILL_CHAR;
        w_adata = r_attr;
        if (r_clr_col == LP_LAST_COL) begin
          w_clr_col = 7'd0;
          if (r_clr_row == 6'd63) begin
            w_offset = 6'd0;
            w_col    = 7'd0;
            w_row    = 6'd0;
            w_state  = ST_IDLE;
          end else begin
            w_clr_row = r_clr_row + 6'd1;
          end
        end else begin
          w_clr_col = r_clr_col + 7'd1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any clear in progress
  always_ff @(posedge CLOCK_CORE) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_acc      <= 1'b0;
      r_bs       <= 1'b0;
      r_clr_done <= 1'b0;
      r_data     <= 8'd0;
      r_attr     <= 8'd0;
      r_col      <= 7'd0;
      r_row      <= 6'd0;
      r_offset   <= 6'd0;
      r_clr_col  <= 7'd0;
      r_clr_row  <= 6'd0;
    end else begin
      r_state    <= w_state;
      r_acc      <= w_acc;
      r_bs       <= w_bs;
      r_clr_done <= w_clr_done;
      r_data     <= w_data;
      r_attr     <= w_attr;
      r_col      <= w_col;
      r_row      <= w_row;
      r_offset   <= w_offset;
      r_clr_col  <= w_clr_col;
      r_clr_row  <= w_clr_row;
    end
  end

endmodule
